// File: rtl/hazard_stall_controller_pkg.sv
// Shared encodings for the pipeline hazard/stall controller: action states and
// forwarding mux selects.
package hazard_stall_controller_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StStall  = 2'd1,
    StFlush  = 2'd2,
    StFreeze = 2'd3
  } action_e;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

endpackage

// File: rtl/hazard_stall_controller_fwd_select_unit.sv
// Per-operand forwarding select: nearest producing stage wins, register 0 never forwards.
module fwd_select_unit
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_fwd_ok,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_le,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rf_le,
  output logic [1:0]        sel
);

  logic src_nz;
  assign src_nz = (src != '0);

  always_comb begin
    sel = FWD_RF;
    if (src_nz) begin
      if (ex_fwd_ok && (ex_rd == src)) begin
        sel = FWD_EX;
      end else if (mem_rf_le && (mem_rd == src)) begin
        sel = FWD_MEM;
      end else if (wb_rf_le && (wb_rd == src)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_stall_controller.sv
// Pipeline sequencing controller: Mealy pipe controls, EX operand forwarding selects,
// registered last action and saturating stall/flush/freeze counters.
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_ra,
  input  logic              id_ra_used,
  input  logic [REG_AW-1:0] id_rb,
  input  logic              id_rb_used,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_rf_le,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_rf_le,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_rf_le,
  input  logic              branch_taken,
  input  logic              mem_busy,
  input  logic              cnt_clr,
  output logic              pc_le,
  output logic              pc_sel_target,
  output logic              if_id_le,
  output logic              if_id_clr,
  output logic              id_ex_bubble,
  output logic              pipe_freeze,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  freeze_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;

  action_e    action, state_q;
  logic       lu;
  logic [1:0] sel_a, sel_b;
  logic [CNT_W-1:0] stall_q, flush_q, freeze_q;

  assign lu = ex_load && ex_rf_le && (ex_rd != '0) &&
              ((id_ra_used && (id_ra == ex_rd)) || (id_rb_used && (id_rb == ex_rd)));

  always_comb begin
    if (mem_busy) begin
      action = StFreeze;
    end else if (branch_taken) begin
      action = StFlush;
    end else if (lu) begin
      action = StStall;
    end else begin
      action = StRun;
    end
  end

  always_comb begin
    pc_le         = 1'b0;
    pc_sel_target = 1'b0;
    if_id_le      = 1'b0;
    if_id_clr     = 1'b0;
    id_ex_bubble  = 1'b0;
    pipe_freeze   = 1'b0;
    if (reset) begin
      id_ex_bubble = 1'b1;
    end else begin
      unique case (action)
        StFreeze: pipe_freeze = 1'b1;
        StFlush: begin
          pc_le         = 1'b1;
          pc_sel_target = 1'b1;
          if_id_le      = 1'b1;
          if_id_clr     = 1'b1;
        end
        StStall: id_ex_bubble = 1'b1;
        default: begin
          pc_le    = 1'b1;
          if_id_le = 1'b1;
        end
      endcase
    end
  end

  fwd_select_unit #(.REG_AW(REG_AW)) u_fwd_a (
    .src       (id_ra),
    .ex_rd     (ex_rd),
    .ex_fwd_ok (ex_rf_le && !ex_load),
    .mem_rd    (mem_rd),
    .mem_rf_le (mem_rf_le),
    .wb_rd     (wb_rd),
    .wb_rf_le  (wb_rf_le),
    .sel       (sel_a)
  );

  fwd_select_unit #(.REG_AW(REG_AW)) u_fwd_b (
    .src       (id_rb),
    .ex_rd     (ex_rd),
    .ex_fwd_ok (ex_rf_le && !ex_load),
    .mem_rd    (mem_rd),
    .mem_rf_le (mem_rf_le),
    .wb_rd     (wb_rd),
    .wb_rf_le  (wb_rf_le),
    .sel       (sel_b)
  );

  assign fwd_a_sel = reset ? FWD_RF : sel_a;
  assign fwd_b_sel = reset ? FWD_RF : sel_b;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRun;
    end else begin
      state_q <= action;
    end
  end

  // Clear beats increment; each counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      stall_q  <= '0;
      flush_q  <= '0;
      freeze_q <= '0;
    end else begin
      if ((action == StStall) && (stall_q != CntMax))   stall_q  <= stall_q + 1'b1;
      if ((action == StFlush) && (flush_q != CntMax))   flush_q  <= flush_q + 1'b1;
      if ((action == StFreeze) && (freeze_q != CntMax)) freeze_q <= freeze_q + 1'b1;
    end
  end

  assign state      = state_q;
  assign stall_cnt  = stall_q;
  assign flush_cnt  = flush_q;
  assign freeze_cnt = freeze_q;

endmodule
